// File: rtl/shift_issue_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// shift_issue_ctrl_pkg
// Shared definitions for the shift-instruction issue front end:
//   - R-type opcode and the six shift funct codes
//   - 3-bit shift-ALU control codes (SHC_NONE makes the ALU output 0)
//   - FSM state enum for shift_issue_ctrl
// ----------------------------------------------------------------------------
package shift_issue_ctrl_pkg;

    localparam logic [5:0] OPC_RTYPE  = 6'b000000;

    localparam logic [5:0] FUNCT_SLL  = 6'b000000;
    localparam logic [5:0] FUNCT_SRL  = 6'b000010;
    localparam logic [5:0] FUNCT_SRA  = 6'b000011;
    localparam logic [5:0] FUNCT_SLLV = 6'b000100;
    localparam logic [5:0] FUNCT_SRLV = 6'b000110;
    localparam logic [5:0] FUNCT_SRAV = 6'b000111;

    // Control bit 0 selects the variable amount, bit 1 selects right shift,
    // bit 2 selects arithmetic; 100 on its own is the "no operation" code.
    localparam logic [2:0] SHC_SLL  = 3'b000;
    localparam logic [2:0] SHC_SRL  = 3'b010;
    localparam logic [2:0] SHC_SRA  = 3'b110;
    localparam logic [2:0] SHC_SLLV = 3'b001;
    localparam logic [2:0] SHC_SRLV = 3'b011;
    localparam logic [2:0] SHC_SRAV = 3'b111;
    localparam logic [2:0] SHC_NONE = 3'b100;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_e;

endpackage : shift_issue_ctrl_pkg

// File: rtl/shift_funct_decode.sv
// ----------------------------------------------------------------------------
// shift_funct_decode
// Combinational decode of opcode/funct into the shift-ALU control code.
// Ports:
//   i_opcode  [5:0]  instruction opcode field
//   i_funct   [5:0]  instruction funct field
//   o_sh_cont [2:0]  shift-ALU control (SHC_NONE for anything not a shift)
//   o_illegal        1 when the instruction is not one of the six shifts
// ----------------------------------------------------------------------------
module shift_funct_decode
    import shift_issue_ctrl_pkg::*;
(
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_funct,
    output logic [2:0] o_sh_cont,
    output logic       o_illegal
);

    always_comb begin
        // NOTE: both outputs get a default before any branch so every path
        // assigns them and no latch is inferred.
        o_sh_cont = SHC_NONE;
        o_illegal = 1'b1;
        if (i_opcode == OPC_RTYPE) begin
            o_illegal = 1'b0;
            case (i_funct)
                FUNCT_SLL:  o_sh_cont = SHC_SLL;
                FUNCT_SRL:  o_sh_cont = SHC_SRL;
                FUNCT_SRA:  o_sh_cont = SHC_SRA;
                FUNCT_SLLV: o_sh_cont = SHC_SLLV;
                FUNCT_SRLV: o_sh_cont = SHC_SRLV;
                FUNCT_SRAV: o_sh_cont = SHC_SRAV;
                default: begin
                    o_sh_cont = SHC_NONE;
                    o_illegal = 1'b1;
                end
            endcase
        end
    end

endmodule : shift_funct_decode

// File: rtl/shift_issue_ctrl.sv
// ----------------------------------------------------------------------------
// shift_issue_ctrl
// Sequential front end for the combinational shift ALU. Accepts one decoded
// R-type shift per handshake, registers the ALU control bundle, captures the
// ALU result one cycle later and offers it downstream with the rd index.
//
// Optional feature: define SHIFT_ILLEGAL_TRAP_EN to drive out_illegal=1
// alongside the (zero) result of a non-shift instruction. Without it,
// out_illegal is tied 0 and such an instruction simply returns 0.
//
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   in_valid / in_ready    upstream handshake (in_ready is combinational)
//   instr, rs_val, rt_val  instruction word and register operands
//   sh_operand, sh_amt,    registered drive to the shift ALU
//   v_sh_amt, sh_cont
//   sh_result              combinational result from the shift ALU
//   out_valid / out_ready  downstream handshake
//   out_data, out_rd       shift result and destination register
//   out_illegal            result came from a non-shift instruction
// ----------------------------------------------------------------------------
module shift_issue_ctrl
    import shift_issue_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic [31:0] sh_operand,
    output logic [5:0]  sh_amt,
    output logic [5:0]  v_sh_amt,
    output logic [2:0]  sh_cont,
    input  logic [31:0] sh_result,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [4:0]  out_rd,
    output logic        out_illegal
);

    state_e      r_state;
    state_e      w_next_state;
    logic        w_accept;
    logic        w_issue;
    logic        w_consume;

    logic [2:0]  w_dec_cont;
    logic        w_dec_illegal;

    logic [31:0] r_sh_operand;
    logic [5:0]  r_sh_amt;
    logic [5:0]  r_v_sh_amt;
    logic [2:0]  r_sh_cont;
    logic        r_illegal;
    logic        r_out_valid;
    logic [31:0] r_out_data;
    logic [4:0]  r_out_rd;

    // Instruction bits outside opcode/rd/shamt/funct and rs_val above bit 4
    // play no part in a shift; gather them so their disuse is explicit.
    logic        w_unused;
    assign w_unused = &{1'b0, instr[25:16], rs_val[31:5]};

    shift_funct_decode u_decode (
        .i_opcode  (instr[31:26]),
        .i_funct   (instr[5:0]),
        .o_sh_cont (w_dec_cont),
        .o_illegal (w_dec_illegal)
    );

    // ------------------------------------------------------------------
    // FSM: next state and handshake strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        w_accept     = 1'b0;
        w_issue      = 1'b0;
        w_consume    = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_accept     = 1'b1;
                    w_next_state = ISSUE;
                end
            end
            ISSUE: begin
                w_issue      = 1'b1;
                w_next_state = RESP;
            end
            RESP: begin
                if (out_ready) begin
                    w_consume    = 1'b1;
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: every register here is reset, including the ALU drive, so the
        // ALU sees a defined no-op (SHC_NONE) until the first instruction.
        if (!rst_n) begin
            r_sh_operand <= '0;
            r_sh_amt     <= '0;
            r_v_sh_amt   <= '0;
            r_sh_cont    <= SHC_NONE;
            r_illegal    <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_rd     <= '0;
        end else begin
            if (w_accept) begin
                r_sh_operand <= rt_val;
                r_sh_amt     <= {1'b0, instr[10:6]};
                r_v_sh_amt   <= {1'b0, rs_val[4:0]};
                r_out_rd     <= instr[15:11];
                r_sh_cont    <= w_dec_cont;
                r_illegal    <= w_dec_illegal;
            end
            if (w_issue) begin
                // SHC_NONE already zeroes the ALU; forcing 0 here keeps the
                // result defined even if the ALU disagrees.
                r_out_data  <= r_illegal ? '0 : sh_result;
                r_out_valid <= 1'b1;
            end
            if (w_consume) begin
                r_out_valid <= 1'b0;
            end
        end
    end

`ifdef SHIFT_ILLEGAL_TRAP_EN
    logic r_out_illegal;

    // Flag tracks out_valid: raised with the result, dropped when consumed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_illegal <= 1'b0;
        end else if (w_issue) begin
            r_out_illegal <= r_illegal;
        end else if (w_consume) begin
            r_out_illegal <= 1'b0;
        end
    end

    assign out_illegal = r_out_illegal;
`else
    assign out_illegal = 1'b0;
`endif

    assign sh_operand = r_sh_operand;
    assign sh_amt     = r_sh_amt;
    assign v_sh_amt   = r_v_sh_amt;
    assign sh_cont    = r_sh_cont;
    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_rd     = r_out_rd;

endmodule : shift_issue_ctrl

// File: doc/shift_issue_ctrl.md
# shift_issue_ctrl

Sequential front end for the combinational shift ALU. Accepts a decoded R-type shift instruction with register operands over a valid/ready handshake and registers the control bundle the shift ALU consumes (operand, immediate amount, variable amount, 3-bit control). It then captures the ALU's result and presents it with the destination register index over a second valid/ready handshake. Sits between the register-read stage and the writeback mux of the datapath.

## Interface
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  synchronous, active-low reset
- `in_valid`  in  1  upstream instruction valid
- `in_ready`  out  1  block can accept an instruction
- `instr`  in  32  instruction word: opcode [31:26], rd [15:11], shamt [10:6], funct [5:0]
- `rs_val`  in  32  rs register value; source of the variable amount
- `rt_val`  in  32  rt register value; the shift operand
- `sh_operand`  out  32  to shift ALU operand
- `sh_amt`  out  6  to shift ALU immediate amount
- `v_sh_amt`  out  6  to shift ALU variable amount
- `sh_cont`  out  3  to shift ALU control
- `sh_result`  in  32  from shift ALU, combinational on the above
- `out_valid`  out  1  result valid
- `out_ready`  in  1  downstream accepts result
- `out_data`  out  32  shift result
- `out_rd`  out  5  destination register index
- `out_illegal`  out  1  instruction was not a legal shift (macro-dependent, see Configuration)

## Operation
- FSM states: IDLE, ISSUE, RESP. Reset places the FSM in IDLE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid`: register `sh_operand`=`rt_val`, `sh_amt`={1'b0,`instr`[10:6]}, `v_sh_amt`={1'b0,`rs_val`[4:0]}, `out_rd`=`instr`[15:11], and the decoded `sh_cont`.
  - Then go to ISSUE.
- **Decode**
  - Applies only when opcode=000000. Map funct to `sh_cont` as follows:
    - SLL 000000→000
    - SRL 000010→010
    - SRA 000011→110
    - SLLV 000100→001
    - SRLV 000110→011
    - SRAV 000111→111
  - Any other opcode or funct is illegal: `sh_cont`=100, which makes the ALU output 0.
- **ISSUE**
  - Shift ALU outputs are stable for this cycle.
  - Capture `sh_result` into `out_data`, set `out_valid`=1, go to RESP.
- **RESP**
  - Hold `out_data`, `out_rd` and `out_illegal` stable.
  - On `out_ready`: clear `out_valid` and return to IDLE.
- `in_ready` is 0 in ISSUE and RESP. No new instruction is accepted until the result is consumed.
- Shift-ALU drive registers hold their last value outside ISSUE. They are don't-care to consumers.
- rs_val[5] and above are ignored; the variable amount is always 0–31.

## Timing
- Reset values:
  - FSM=IDLE
  - `in_ready`=1 (combinational from state)
  - `out_valid`=0, `out_data`=0, `out_rd`=0, `out_illegal`=0
  - `sh_operand`=0, `sh_amt`=0, `v_sh_amt`=0, `sh_cont`=100
- Latency: handshake accepted at edge N → ISSUE after N → `out_valid` high after edge N+1.
- Minimum 3 cycles per instruction when `out_ready` is held high.
- `out_ready` high with `out_valid` low is ignored.
- `in_valid` dropped while `in_ready`=0 has no effect.
- Reset asserted in ISSUE or RESP abandons the instruction. The pending result is never presented.
- All outputs are registered except `in_ready`.

## Configuration
- Macro: `SHIFT_ILLEGAL_TRAP_EN`.
- **Defined:**
  - An illegal instruction still flows through ISSUE and RESP with `out_data`=0.
  - `out_illegal`=1 with `out_valid`.
  - Downstream must suppress writeback.
- **Undefined:**
  - `out_illegal` is tied 0.
  - An illegal instruction returns `out_data`=0 as an ordinary result.

## Structure
- Shared package holds:
  - funct codes: `FUNCT_SLL`, `FUNCT_SRL`, `FUNCT_SRA`, `FUNCT_SLLV`, `FUNCT_SRLV`, `FUNCT_SRAV`
  - `OPC_RTYPE`
  - the 3-bit shift control constants, including `SHC_NONE`=100
  - the FSM state enum
- One natural sub-module: `shift_funct_decode`, combinational opcode/funct → {`sh_cont`, illegal}.
- The FSM and registers live in the top.

## Test plan
The bench drives `sh_result` from a behavioural shift model with true arithmetic semantics for codes 110/111.
- **Reset:** reset for 2 cycles → `out_valid`=0, `in_ready`=1, `sh_cont`=100.
- **SLL:** shamt=4, rt=0x0000000F, rd=3 → `sh_cont`=000, `sh_amt`=4; two cycles later `out_data`=0x000000F0, `out_rd`=3.
- **SRAV:** rs=0x00000021, rt=0x80000000 → `v_sh_amt`=1, `sh_cont`=111, `out_data`=0xC0000000.
- **Backpressure:** `out_ready`=0 for 5 cycles in RESP → `out_data` and `out_rd` stable, `in_ready`=0, a new `in_valid` is not accepted; `out_ready`=1 → IDLE next cycle.
- **Illegal:** funct=100000 → `sh_cont`=100, `out_data`=0; `out_illegal`=1 only with `SHIFT_ILLEGAL_TRAP_EN` defined.
- **Reset mid-flight:** `rst_n`=0 during RESP → next cycle `out_valid`=0, FSM IDLE, no result ever presented.
